// File: rtl/riscv_v_permutation_unit.sv
// riscv_v_permutation_unit
//   Sequential scalar<->vector move / slide-by-one unit sitting between vector
//   issue and writeback. One request is accepted in IDLE, evaluated in EXEC
//   from the captured copy only, and the registered result is held in DONE
//   until the consumer takes it.
//
//   state | meaning
//   IDLE  | in_ready = 1, waiting for in_valid; captures the request
//   EXEC  | computes the result from the captured request, registers outputs
//   DONE  | out_valid = 1, outputs held until out_ready
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake
//   op, sew, vl, idx    operation, element width, active length, V2I index
//   int_in, vec_in      scalar and vector source operands
//   out_valid/out_ready result handshake
//   int_out             scalar result (V2I only)
//   vec_out, vec_out_be vector result and per-byte write enables
//   out_err             illegal request (sew = 3)

module riscv_v_permutation_unit #(
  parameter int VLEN = 128,
  parameter int XLEN = 32,
  parameter int VL_W = $clog2(VLEN/8) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [1:0]        sew,
  input  logic [VL_W-1:0]   vl,
  input  logic [VL_W-1:0]   idx,
  input  logic [XLEN-1:0]   int_in,
  input  logic [VLEN-1:0]   vec_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   int_out,
  output logic [VLEN-1:0]   vec_out,
  output logic [VLEN/8-1:0] vec_out_be,
  output logic              out_err
);

  localparam int NB = VLEN / 8;

  localparam logic [1:0] OP_I2V   = 2'd0;
  localparam logic [1:0] OP_V2I   = 2'd1;
  localparam logic [1:0] OP_SLUP  = 2'd2;
  localparam logic [1:0] OP_SLDN  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [1:0]      op_q, sew_q;
  logic [VL_W-1:0] vl_q, idx_q;
  logic [XLEN-1:0] int_in_q;
  logic [VLEN-1:0] vec_in_q;

  logic [XLEN-1:0] res_int;
  logic [VLEN-1:0] res_vec;
  logic [NB-1:0]   res_be;
  logic            res_err;

  logic [VLEN-1:0] up_src, dn_src, elem_sh;
  int              esz, n_elem, veff, elem, off;

  function automatic logic [7:0] byte_of(input logic [XLEN-1:0] v, input int k);
    logic [XLEN-1:0] s;
    s = v >> (k * 8);
    return s[7:0];
  endfunction

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_EXEC;
      S_EXEC:  state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // handshake outputs
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
  end

  // request capture; only the accept edge samples the inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      sew_q    <= '0;
      vl_q     <= '0;
      idx_q    <= '0;
      int_in_q <= '0;
      vec_in_q <= '0;
    end else if (state_q == S_IDLE && in_valid) begin
      op_q     <= op;
      sew_q    <= sew;
      vl_q     <= vl;
      idx_q    <= idx;
      int_in_q <= int_in;
      vec_in_q <= vec_in;
    end
  end

  // Result datapath. Slides are done on whole-vector shifts by one element
  // so that each destination byte just picks the byte at the same position
  // of the shifted source, avoiding out-of-range byte selects.
  always_comb begin
    res_int = '0;
    res_vec = '0;
    res_be  = '0;
    res_err = 1'b0;
    esz     = 1 << sew_q;
    n_elem  = NB >> sew_q;
    veff    = (int'(vl_q) < n_elem) ? int'(vl_q) : n_elem;
    up_src  = vec_in_q << (esz * 8);
    dn_src  = vec_in_q >> (esz * 8);
    elem_sh = vec_in_q >> (int'(idx_q) * esz * 8);
    elem    = 0;
    off     = 0;

    if (sew_q == 2'd3) begin
      res_err = 1'b1;
    end else if (op_q == OP_V2I) begin
      if (int'(idx_q) < n_elem) begin
        case (sew_q)
          2'd0:    res_int = XLEN'($signed(elem_sh[7:0]));
          2'd1:    res_int = XLEN'($signed(elem_sh[15:0]));
          default: res_int = XLEN'($signed(elem_sh[31:0]));
        endcase
      end
    end else begin
      for (int b = 0; b < NB; b++) begin
        elem = b >> sew_q;
        off  = b - (elem << sew_q);
        if (elem < veff) begin
          case (op_q)
            OP_I2V: begin
              if (elem == 0) begin
                res_vec[b*8 +: 8] = byte_of(int_in_q, off);
                res_be[b]         = 1'b1;
              end
            end
            OP_SLUP: begin
              res_vec[b*8 +: 8] = (elem == 0) ? byte_of(int_in_q, off) : up_src[b*8 +: 8];
              res_be[b]         = 1'b1;
            end
            OP_SLDN: begin
              res_vec[b*8 +: 8] = (elem == veff - 1) ? byte_of(int_in_q, off) : dn_src[b*8 +: 8];
              res_be[b]         = 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // registered results: loaded in EXEC, held through DONE, cleared on accept
  always_ff @(posedge clk) begin
    if (rst) begin
      int_out    <= '0;
      vec_out    <= '0;
      vec_out_be <= '0;
      out_err    <= 1'b0;
    end else if (state_q == S_EXEC) begin
      int_out    <= res_int;
      vec_out    <= res_vec;
      vec_out_be <= res_be;
      out_err    <= res_err;
    end else if (state_q == S_DONE && out_ready) begin
      int_out    <= '0;
      vec_out    <= '0;
      vec_out_be <= '0;
      out_err    <= 1'b0;
    end
  end

endmodule
